pc_unit: RTL and testbench

- Parametrised fetch-stage program-counter unit; successor to the plain enable-gated PC register.
- Adds in-unit next-PC selection: sequential, branch/jump redirect, exception vector and eret return.
- Holds a one-deep pending-redirect buffer so a redirect raised during a stall is not lost.
- Flags fetch-address errors (misalignment or outside instruction memory) for the CP0/exception logic.

---
 rtl/pc_if.sv | 28 ++
 rtl/pc_unit.sv | 73 +++++++
 tb/tb_pc_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_if.sv
// Fetch PC bundle: redirect requests in, current PC and status out.
// The pipeline side drives requests; the PC unit answers with fetch state.
interface pc_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             br_valid;
    logic [WIDTH-1:0] br_target;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_step;
    logic             pend_valid;
    logic             adel;

    modport master (
        output en, br_valid, br_target,
        output exc_req, eret, epc,
        input  pc, pc_plus_step, pend_valid, adel
    );

    modport slave (
        input  en, br_valid, br_target,
        input  exc_req, eret, epc,
        output pc, pc_plus_step, pend_valid, adel
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC select and a one-deep
// pending-redirect buffer that preserves a branch raised during a stall.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter int               STEP       = 4,
    parameter logic [WIDTH-1:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IMEM_SIZE  = 32'h0000_1000
) (
    input logic clk,
    input logic reset,
    pc_if.slave bus
);
    // One extra bit so a window ending at 2^WIDTH does not overflow.
    localparam logic [WIDTH:0] IMEM_END =
        {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

    logic [WIDTH-1:0] pc_q,   pc_d;
    logic [WIDTH-1:0] tgt_q,  tgt_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + WIDTH'(STEP);

    always_comb begin
        pc_d   = pc_q;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        priority case (1'b1)
            bus.exc_req: begin
                pc_d   = EXC_VECTOR;
                pend_d = 1'b0;
            end
            bus.eret: begin
                pc_d   = bus.epc;
                pend_d = 1'b0;
            end
            bus.en && pend_q: begin
                pc_d   = tgt_q;
                pend_d = 1'b0;
            end
            bus.en && bus.br_valid: pc_d = bus.br_target;
            bus.en:                 pc_d = pc_inc;
            default: begin
                // Stalled: keep only the first redirect seen.
                if (bus.br_valid && !pend_q) begin
                    tgt_d  = bus.br_target;
                    pend_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_ADDR;
            tgt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus_step = pc_inc;
    assign bus.pend_valid   = pend_q;
    assign bus.adel         = (pc_q[1:0] != 2'b00)
                            || (pc_q < IMEM_BASE)
                            || ({1'b0, pc_q} >= IMEM_END);
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a reference model checked every cycle
// plus literal expectations from the test plan; also a 16-bit wrap case.
module tb_pc_unit;
    localparam logic [31:0] RST_A = 32'h3000;
    localparam logic [31:0] EXC_A = 32'h4180;
    localparam longint      BASE  = 64'h3000;
    localparam longint      SIZE  = 64'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_if #(.WIDTH(32)) b32 ();
    pc_if #(.WIDTH(16)) b16 ();

    pc_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (b32.slave)
    );

    pc_unit #(
        .WIDTH     (16),
        .RESET_ADDR(16'h3000),
        .EXC_VECTOR(16'h4180),
        .STEP      (4),
        .IMEM_BASE (16'h3000),
        .IMEM_SIZE (16'h1000)
    ) dut16 (
        .clk  (clk),
        .reset(rst),
        .bus  (b16.slave)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: architectural PC, pending flag and saved target.
    logic [31:0] m_pc   = RST_A;
    logic [31:0] m_tgt  = '0;
    bit          m_pend = 1'b0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RST_A; m_pend = 0; m_tgt = '0; started = 1;
        end else if (b32.exc_req) begin
            m_pc = EXC_A; m_pend = 0;
        end else if (b32.eret) begin
            m_pc = b32.epc; m_pend = 0;
        end else if (b32.en) begin
            if (m_pend) begin
                m_pc = m_tgt; m_pend = 0;
            end else if (b32.br_valid) m_pc = b32.br_target;
            else m_pc = m_pc + 32'd4;
        end else if (b32.br_valid && !m_pend) begin
            m_tgt = b32.br_target; m_pend = 1;
        end
    end

    function automatic bit m_adel(logic [31:0] a);
        longint v = longint'(a);
        return (v % 4 != 0) || (v < BASE) || (v >= BASE + SIZE);
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("model_pc",   b32.pc, m_pc);
            chk("model_next", b32.pc_plus_step, m_pc + 32'd4);
            chk("model_pend", 32'(b32.pend_valid), 32'(m_pend));
            chk("model_adel", 32'(b32.adel), 32'(m_adel(m_pc)));
        end
    end

    task automatic cyc(bit e, bit br, logic [31:0] t,
                       bit x = 0, bit r = 0, logic [31:0] ep = 0);
        b32.en = e; b32.br_valid = br; b32.br_target = t;
        b32.exc_req = x; b32.eret = r; b32.epc = ep;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        b16.en = 0; b16.br_valid = 0; b16.br_target = '0;
        b16.exc_req = 0; b16.eret = 0; b16.epc = '0;
        rst = 1;
        cyc(0, 0, 0);
        rst = 0;
        chk("rst_pc", b32.pc, 32'h3000);
        chk("rst_pend", 32'(b32.pend_valid), 0);
        chk("rst_adel", 32'(b32.adel), 0);

        cyc(1, 0, 0); chk("seq1", b32.pc, 32'h3004);
        cyc(1, 0, 0); chk("seq2", b32.pc, 32'h3008);
        cyc(1, 0, 0); chk("seq3", b32.pc, 32'h300C);
        chk("seq_adel", 32'(b32.adel), 0);
        cyc(1, 0, 0); chk("seq4", b32.pc, 32'h3010);

        cyc(0, 1, 32'h3100); chk("stall_pc", b32.pc, 32'h3010);
        chk("stall_pend", 32'(b32.pend_valid), 1);
        cyc(0, 1, 32'h3100);
        cyc(0, 1, 32'h3200); chk("stall_hold", b32.pc, 32'h3010);
        cyc(1, 0, 0); chk("pend_take", b32.pc, 32'h3100);
        chk("pend_clr", 32'(b32.pend_valid), 0);

        cyc(0, 1, 32'h3300); chk("pend2", 32'(b32.pend_valid), 1);
        cyc(0, 0, 0, 1); chk("exc_pc", b32.pc, 32'h4180);
        chk("exc_pend", 32'(b32.pend_valid), 0);
        chk("exc_adel", 32'(b32.adel), 1);
        cyc(0, 0, 0, 0, 1, 32'h3024); chk("eret_pc", b32.pc, 32'h3024);

        cyc(1, 1, 32'h3500, 1, 1, 32'h3600);
        chk("exc_wins", b32.pc, 32'h4180);

        cyc(1, 1, 32'h3002); chk("mis_pc", b32.pc, 32'h3002);
        chk("mis_adel", 32'(b32.adel), 1);
        cyc(1, 1, 32'h4000); chk("top_adel", 32'(b32.adel), 1);
        cyc(1, 1, 32'h3FFC); chk("last_adel", 32'(b32.adel), 0);
        chk("last_next", b32.pc_plus_step, 32'h4000);

        cyc(0, 1, 32'h3500); chk("pend3", 32'(b32.pend_valid), 1);
        rst = 1;
        cyc(0, 1, 32'h3500);
        rst = 0;
        chk("mid_rst_pc", b32.pc, 32'h3000);
        chk("mid_rst_pend", 32'(b32.pend_valid), 0);
        cyc(1, 0, 0); chk("post_rst", b32.pc, 32'h3004);

        b16.en = 1; b16.br_valid = 1; b16.br_target = 16'hFFFC;
        @(posedge clk); @(negedge clk);
        chk("w16_pc", 32'(b16.pc), 32'hFFFC);
        chk("w16_next", 32'(b16.pc_plus_step), 32'h0000);
        chk("w16_adel", 32'(b16.adel), 1);
        b16.br_valid = 0;
        @(posedge clk); @(negedge clk);
        chk("w16_wrap", 32'(b16.pc), 32'h0000);
        chk("w16_low_adel", 32'(b16.adel), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
